// File: rtl/mmu_select_arbiter_pkg.sv
// Shared types and defaults for the MMU selector arbiter.
// Holds the FSM state enum, default sizing and the pointer-width helper.
package mmu_sel_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } selState_t;

    localparam int DEF_NUM_PORTS      = 4;
    localparam int DEF_TIMEOUT_CYCLES = 256;

    // clog2 that never returns 0, so single-entry vectors still get one bit
    function automatic int ptrWidth(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mmu_select_arbiter_if.sv
// Request/selector bundle between requesters, the arbiter and the 4-way selector.
// master = arbiter side, slave = requesters plus selector side.
interface mmu_select_arbiter_if
    import mmu_sel_pkg::*;
#(
    parameter int NUM_PORTS = DEF_NUM_PORTS
);
    logic [NUM_PORTS-1:0] i_req;
    logic [NUM_PORTS-1:0] o_ack;
    logic [NUM_PORTS-1:0] o_select;
    logic                 o_drive;
    logic                 i_free;
    logic [NUM_PORTS-1:0] i_done;
    logic                 o_busy;
    logic                 o_err;

    modport master (
        input  i_req, i_free, i_done,
        output o_ack, o_select, o_drive, o_busy, o_err
    );

    modport slave (
        output i_req, i_free, i_done,
        input  o_ack, o_select, o_drive, o_busy, o_err
    );
endinterface

// File: rtl/mmu_select_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate requests so rrPtr lands on bit 0,
// isolate the lowest set bit, rotate the one-hot grant back.
module mmu_rr_pick #(
    parameter int NUM_PORTS = 4,
    parameter int PTR_W     = 2
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PTR_W-1:0]     rrPtr,
    output logic [NUM_PORTS-1:0] grant
);
    logic [2*NUM_PORTS-1:0] reqDouble;
    logic [2*NUM_PORTS-1:0] reqShift;
    logic [NUM_PORTS-1:0]   reqRot;
    logic [NUM_PORTS-1:0]   grantRot;
    logic [2*NUM_PORTS-1:0] grantDouble;

    assign reqDouble   = {req, req};
    assign reqShift    = reqDouble >> rrPtr;
    assign reqRot      = reqShift[NUM_PORTS-1:0];
    // two's-complement trick keeps only the lowest set bit
    assign grantRot    = reqRot & (~reqRot + NUM_PORTS'(1));
    assign grantDouble = {grantRot, grantRot} << rrPtr;
    assign grant       = grantDouble[2*NUM_PORTS-1:NUM_PORTS];

endmodule

// File: rtl/mmu_select_arbiter.sv
// Round-robin arbiter sharing one MMU selector stage among NUM_PORTS requesters.
// Optional WAIT watchdog with sticky o_err is built when MMU_SEL_TIMEOUT_EN is defined.
module mmu_select_arbiter
    import mmu_sel_pkg::*;
#(
    parameter int NUM_PORTS      = DEF_NUM_PORTS,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                clk,
    input  logic                rst,
    mmu_select_arbiter_if.master bus
);
    localparam int PTR_W = ptrWidth(NUM_PORTS);

    selState_t            stateReg, stateNext;
    logic [NUM_PORTS-1:0] selReg, selNext;
    logic [NUM_PORTS-1:0] grant;
    logic [PTR_W-1:0]     rrPtrReg, rrPtrNext;
    logic [PTR_W-1:0]     selIdx;
    logic [PTR_W-1:0]     idxTerms [NUM_PORTS];
    logic                 freeSeenReg, freeSeenNext;
    logic                 doneSeenReg, doneSeenNext;
    logic                 doneHit;
    logic                 complete;
    logic                 timeoutHit;

    mmu_rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .PTR_W     (PTR_W)
    ) rrPick (
        .req   (bus.i_req),
        .rrPtr (rrPtrReg),
        .grant (grant)
    );

    // selReg is one-hot, so OR-ing the gated indices yields its position
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : gIdx
        assign idxTerms[gi] = selReg[gi] ? PTR_W'(gi) : '0;
    end

    always_comb begin
        selIdx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            selIdx = selIdx | idxTerms[i];
        end
    end

    assign doneHit  = |(bus.i_done & selReg);
    assign complete = (freeSeenReg | bus.i_free) & (doneSeenReg | doneHit);

`ifdef MMU_SEL_TIMEOUT_EN
    localparam int CNT_W = ptrWidth(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cntReg, cntNext;
    logic             errReg, errNext;

    assign timeoutHit = (stateReg == WAIT) && (cntReg == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cntNext = cntReg;
        errNext = errReg;
        if (stateReg == DRIVE) begin
            cntNext = '0;
        end else if (stateReg == WAIT) begin
            cntNext = cntReg + CNT_W'(1);
        end
        if (timeoutHit && !complete) begin
            errNext = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cntReg <= '0;
            errReg <= 1'b0;
        end else begin
            cntReg <= cntNext;
            errReg <= errNext;
        end
    end

    assign bus.o_err = errReg;
`else
    assign timeoutHit = 1'b0;
    assign bus.o_err  = 1'b0;
`endif

    always_comb begin
        stateNext    = stateReg;
        selNext      = selReg;
        rrPtrNext    = rrPtrReg;
        freeSeenNext = freeSeenReg;
        doneSeenNext = doneSeenReg;
        bus.o_ack    = '0;
        bus.o_select = '0;
        bus.o_drive  = 1'b0;

        case (stateReg)
            IDLE: begin
                if (|bus.i_req) begin
                    selNext   = grant;
                    stateNext = DRIVE;
                end
            end
            DRIVE: begin
                bus.o_drive  = 1'b1;
                bus.o_select = selReg;
                freeSeenNext = 1'b0;
                doneSeenNext = 1'b0;
                stateNext    = WAIT;
            end
            WAIT: begin
                bus.o_select = selReg;
                freeSeenNext = freeSeenReg | bus.i_free;
                doneSeenNext = doneSeenReg | doneHit;
                if (complete || timeoutHit) begin
                    stateNext = ACK;
                end
            end
            ACK: begin
                bus.o_ack = selReg;
                rrPtrNext = (selIdx == PTR_W'(NUM_PORTS - 1)) ? '0 : selIdx + PTR_W'(1);
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    assign bus.o_busy = (stateReg != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg    <= IDLE;
            selReg      <= '0;
            rrPtrReg    <= '0;
            freeSeenReg <= 1'b0;
            doneSeenReg <= 1'b0;
        end else begin
            stateReg    <= stateNext;
            selReg      <= selNext;
            rrPtrReg    <= rrPtrNext;
            freeSeenReg <= freeSeenNext;
            doneSeenReg <= doneSeenNext;
        end
    end

endmodule
